hilo_muldiv_unit: RTL and testbench
===================================

Name: hilo_muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage, alongside ALU32Bit.
- Owns the architectural Hi/Lo registers and replaces the combinational Hi/Lo path for mult/div-class instructions.
- Accepts one operation per Start pulse and computes it over 32 shift iterations.
- Raises Stall to the hazard detection unit while busy, so dependent mfhi/mflo instructions and new mult/div instructions wait.

Parameters:
- WIDTH, 32, operand and Hi/Lo width.
- ITER, 32, iteration count; must equal WIDTH.

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  asynchronous reset, active-low.
- Start  in  1  issue strobe from ID/EX; sampled only in IDLE.
- Op  in  3  operation code (see package).
- A  in  WIDTH  R[rs].
- B  in  WIDTH  R[rt].
- Cancel  in  1  pipeline flush; aborts an in-flight operation.
- HiLoRead  in  1  ID-stage instruction reads Hi or Lo (mfhi/mflo).
- Busy  out  1  operation in flight.
- Done  out  1  one-cycle pulse; Hi/Lo updated this cycle.
- Stall  out  1  Busy & (HiLoRead | Start).
- HiOUT  out  WIDTH  Hi register.
- LoOUT  out  WIDTH  Lo register.

Behaviour:
- Reset (Rst=0, any time, asynchronous): state=IDLE; HiOUT=0, LoOUT=0, Busy=0, Done=0, iteration counter=0. An in-flight operation is discarded.
- States:
  - IDLE -> RUN on a Start edge (E0) with a long op.
  - RUN -> FIX after ITER iterations (edges E1..E32).
  - FIX -> IDLE at E33.
- Latency: Busy=1 from after E0 to after E33. Hi/Lo are written at E33 and Done=1 for exactly the cycle after E33. Busy falls on the same edge Done rises. Stall=0 in that Done cycle.
- Ops:
  - MULT/MULTU: {Hi,Lo} = A*B, 64-bit signed/unsigned.
  - DIV/DIVU: Lo = quotient, Hi = remainder.
  - MADD/MSUB: {Hi,Lo} = {Hi,Lo} ± signed A*B, using the Hi/Lo values present at E33.
  - MTHI/MTLO: single cycle. Hi or Lo = A at E0; Busy stays 0; no Done.
- Signed handling:
  - Operands are converted to magnitudes at E0.
  - FIX negates the product when sign(A)^sign(B).
  - For division, the quotient takes sign(A)^sign(B) and the remainder takes sign(A), truncating toward zero.
  - -2^31 / -1 gives Lo=0x80000000, Hi=0.
- Multiply datapath: radix-2 shift-add, 64-bit accumulator, one multiplier bit per RUN cycle.
- Divide datapath: restoring, one quotient bit per RUN cycle, 33-bit partial remainder.
- Divide by zero: completes in normal latency; Lo=0xFFFFFFFF, Hi=A (the original signed A for DIV). No trap.
- Start while Busy: ignored; the requester is held by Stall.
- Start with an undefined Op code: ignored, state unchanged.
- Cancel while Busy: next edge returns to IDLE; Hi/Lo unchanged; no Done.
- Cancel in IDLE: Start in the same cycle is ignored.
- Cancel in the FIX cycle: takes priority; no write.
- HiOUT/LoOUT always reflect the registered architectural values. Partial results are never visible.

Decomposition:
- Package muldiv_pkg holds:
  - Op encodings: MULT=0, MULTU=1, DIV=2, DIVU=3, MADD=4, MSUB=5, MTHI=6, MTLO=7.
  - State enum IDLE/RUN/FIX.
  - ITER_W = clog2(ITER)+1.
- One natural sub-module: muldiv_datapath. It holds the shared accumulator/remainder register, the shift-add/subtract step, and the FIX-stage sign correction. The top holds the FSM, counter, Hi/Lo registers and the handshake.

Test Plan:
- Reset then MULT A=-3 B=5: Done after 33 edges; Hi=0xFFFFFFFF, Lo=0xFFFFFFF1; Busy high for 33 cycles; Stall=1 when HiLoRead=1 during Busy.
- DIVU A=100 B=7: Lo=14, Hi=2. Then DIV A=-7 B=2: Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
- DIV A=5 B=0: Lo=0xFFFFFFFF, Hi=5, normal latency. DIV A=0x80000000 B=0xFFFFFFFF: Lo=0x80000000, Hi=0.
- MTHI A=0 and MTLO A=10, then MADD A=4 B=5: Lo=30, Hi=0. Then MSUB A=1 B=31: Lo=0xFFFFFFFF, Hi=0xFFFFFFFF.
- MULTU 0xFFFFFFFF*0xFFFFFFFF with Cancel at E10: Busy drops next edge; Hi/Lo keep the prior values; no Done. A second Start while Busy is ignored.
- Rst low at E20 of a DIV: all outputs 0 asynchronously. A new MULT 2*3 after release gives Lo=6, Hi=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : muldiv_pkg                                                 |
// | Description : Shared op codes, FSM states and helpers for the iterative  |
// |               Hi/Lo multiply/divide unit.                                |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package muldiv_pkg;

  // Operation codes as issued from ID/EX
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MADD  = 3'd4,
    OP_MSUB  = 3'd5,
    OP_MTHI  = 3'd6,
    OP_MTLO  = 3'd7
  } muldiv_op_e;

  // Control states of the unit
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } muldiv_state_e;

  localparam int DEFAULT_ITER = 32;

  // Counter width able to hold the value ITER itself
  function automatic int iterWidth(input int iter);
    return $clog2(iter) + 1;
  endfunction

  localparam int ITER_W = iterWidth(DEFAULT_ITER);

  // Op codes the unit accepts; anything else is dropped at issue
  function automatic logic isKnownOp(input logic [2:0] op);
    logic known;
    known = 1'b0;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
      OP_MADD, OP_MSUB, OP_MTHI, OP_MTLO: known = 1'b1;
      default:                            known = 1'b0;
    endcase
    return known;
  endfunction

  // Ops that treat A and B as two's-complement values
  function automatic logic isSignedOp(input muldiv_op_e op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  // Moves into Hi/Lo finish in the issue cycle
  function automatic logic isShortOp(input muldiv_op_e op);
    return (op == OP_MTHI) || (op == OP_MTLO);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_datapath.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : muldiv_datapath                                            |
// | Description : Shared accumulator / partial-remainder register with the   |
// |               radix-2 shift-add and restoring-divide steps, plus the     |
// |               final sign correction and Hi/Lo result formation.          |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_step,
  input  muldiv_op_e       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  output logic [WIDTH-1:0] o_hiRes,
  output logic [WIDTH-1:0] o_loRes
);

  localparam int c_ACC_W = 2 * WIDTH + 1;

  // Upper WIDTH+1 bits: running sum (multiply) or partial remainder (divide).
  // Lower WIDTH bits: multiplier / dividend bits being shifted out, with
  // product low bits / quotient bits shifted in behind them.
  logic [c_ACC_W-1:0] r_acc;
  logic [WIDTH-1:0]   r_opB;
  muldiv_op_e         r_op;
  logic               r_negRes;
  logic               r_negRem;
  logic               r_divZero;

  logic               w_signed;
  logic [WIDTH-1:0]   w_magA;
  logic [WIDTH-1:0]   w_magB;
  logic               w_isDiv;
  logic [WIDTH:0]     w_mulSum;
  logic [c_ACC_W-1:0] w_mulNext;
  logic [WIDTH:0]     w_remShift;
  logic [WIDTH+1:0]   w_trial;
  logic               w_fits;
  logic [c_ACC_W-1:0] w_divNext;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_sProd;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic [2*WIDTH-1:0] w_result;

  assign w_signed = isSignedOp(i_op);
  assign w_magA   = (w_signed && i_a[WIDTH-1]) ? -i_a : i_a;
  assign w_magB   = (w_signed && i_b[WIDTH-1]) ? -i_b : i_b;
  assign w_isDiv  = (r_op == OP_DIV) || (r_op == OP_DIVU);

  // Multiply step: add multiplicand when the current multiplier bit is set,
  // then shift the whole accumulator right by one.
  assign w_mulSum  = r_acc[c_ACC_W-1:WIDTH] + (r_acc[0] ? {1'b0, r_opB} : '0);
  assign w_mulNext = {1'b0, w_mulSum, r_acc[WIDTH-1:1]};

  // Restoring divide step: bring in the next dividend bit, keep the
  // subtraction only when it does not go negative.
  assign w_remShift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_trial    = {1'b0, w_remShift} - {2'b0, r_opB};
  assign w_fits     = ~w_trial[WIDTH+1];
  assign w_divNext  = {(w_fits ? w_trial[WIDTH:0] : w_remShift), r_acc[WIDTH-2:0], w_fits};

  // Operand capture at issue and one iteration per step cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_opB     <= '0;
      r_op      <= OP_MULT;
      r_negRes  <= 1'b0;
      r_negRem  <= 1'b0;
      r_divZero <= 1'b0;
    end else if (i_load) begin
      // |A| serves both as multiplier and as dividend
      r_acc     <= {{(WIDTH+1){1'b0}}, w_magA};
      r_opB     <= w_magB;
      r_op      <= i_op;
      r_negRes  <= w_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
      r_negRem  <= w_signed & i_a[WIDTH-1];
      r_divZero <= (i_b == '0);
    end else if (i_step) begin
      r_acc <= w_isDiv ? w_divNext : w_mulNext;
    end
  end

  assign w_prod  = r_acc[2*WIDTH-1:0];
  assign w_sProd = r_negRes ? -w_prod : w_prod;
  // With a zero divisor the remainder naturally collapses back to |A|,
  // so only the quotient needs forcing.
  assign w_quot  = r_divZero ? '1 : (r_negRes ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
  assign w_rem   = r_negRem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  // Final {Hi,Lo} value presented during the fix-up cycle
  always_comb begin
    w_result = {i_hi, i_lo};
    case (r_op)
      OP_MULT, OP_MULTU: w_result = w_sProd;
      OP_DIV,  OP_DIVU:  w_result = {w_rem, w_quot};
      OP_MADD:           w_result = {i_hi, i_lo} + w_sProd;
      OP_MSUB:           w_result = {i_hi, i_lo} - w_sProd;
      default:           w_result = {i_hi, i_lo};
    endcase
  end

  assign o_hiRes = w_result[2*WIDTH-1:WIDTH];
  assign o_loRes = w_result[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/hilo_muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hilo_muldiv_unit                                           |
// | Description : EX-stage iterative multiply/divide unit owning the Hi/Lo   |
// |               registers; stalls the pipeline while an op is in flight.   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module hilo_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = DEFAULT_ITER
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cancel,
  input  logic             HiLoRead,
  output logic             Busy,
  output logic             Done,
  output logic             Stall,
  output logic [WIDTH-1:0] HiOUT,
  output logic [WIDTH-1:0] LoOUT
);

  localparam int                 c_CNT_W = iterWidth(ITER);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(ITER - 1);

  muldiv_state_e      r_state;
  muldiv_state_e      w_nextState;
  logic [c_CNT_W-1:0] r_count;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  muldiv_op_e         w_opEnum;
  logic               w_issue;
  logic               w_longIssue;
  logic               w_step;
  logic               w_write;
  logic [WIDTH-1:0]   w_hiRes;
  logic [WIDTH-1:0]   w_loRes;

  assign w_opEnum    = muldiv_op_e'(Op);
  assign w_issue     = (r_state == ST_IDLE) & Start & ~Cancel & isKnownOp(Op);
  assign w_longIssue = w_issue & ~isShortOp(w_opEnum);

  // State register
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state and per-cycle datapath controls; Cancel wins in every busy state
  always_comb begin
    w_nextState = r_state;
    w_step      = 1'b0;
    w_write     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_longIssue) begin
          w_nextState = ST_RUN;
        end
      end
      ST_RUN: begin
        if (Cancel) begin
          w_nextState = ST_IDLE;
        end else begin
          w_step = 1'b1;
          if (r_count == c_LAST) begin
            w_nextState = ST_FIX;
          end
        end
      end
      ST_FIX: begin
        w_nextState = ST_IDLE;
        w_write     = ~Cancel;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Iteration counter, cleared whenever no step is taken
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_count <= '0;
    end else if (w_step) begin
      r_count <= r_count + 1'b1;
    end else begin
      r_count <= '0;
    end
  end

  // Architectural Hi/Lo: full result at fix-up, direct moves at issue
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_write) begin
      r_hi <= w_hiRes;
      r_lo <= w_loRes;
    end else if (w_issue && (w_opEnum == OP_MTHI)) begin
      r_hi <= A;
    end else if (w_issue && (w_opEnum == OP_MTLO)) begin
      r_lo <= A;
    end
  end

  // Completion pulse aligned with the Hi/Lo update
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_write;
    end
  end

  muldiv_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk     (Clk),
    .rst_n   (Rst),
    .i_load  (w_longIssue),
    .i_step  (w_step),
    .i_op    (w_opEnum),
    .i_a     (A),
    .i_b     (B),
    .i_hi    (r_hi),
    .i_lo    (r_lo),
    .o_hiRes (w_hiRes),
    .o_loRes (w_loRes)
  );

  assign Busy  = (r_state != ST_IDLE);
  assign Done  = r_done;
  assign Stall = Busy & (HiLoRead | Start);
  assign HiOUT = r_hi;
  assign LoOUT = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_hilo_muldiv_unit                                        |
// | Description : Scoreboard bench for hilo_muldiv_unit with an arithmetic   |
// |               reference model and randomized operations.                 |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_hilo_muldiv_unit;

  localparam logic [2:0] c_MULT  = 3'd0;
  localparam logic [2:0] c_MULTU = 3'd1;
  localparam logic [2:0] c_DIV   = 3'd2;
  localparam logic [2:0] c_DIVU  = 3'd3;
  localparam logic [2:0] c_MADD  = 3'd4;
  localparam logic [2:0] c_MSUB  = 3'd5;
  localparam logic [2:0] c_MTHI  = 3'd6;
  localparam logic [2:0] c_MTLO  = 3'd7;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        Start = 1'b0;
  logic [2:0]  Op = 3'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        Cancel = 1'b0;
  logic        HiLoRead = 1'b0;
  logic        Busy;
  logic        Done;
  logic        Stall;
  logic [31:0] HiOUT;
  logic [31:0] LoOUT;

  int          nChecks = 0;
  int          nErrors = 0;
  logic [63:0] expQ[$];
  logic [63:0] monExp;
  logic [31:0] mHi = 32'd0;
  logic [31:0] mLo = 32'd0;

  always #5 Clk = ~Clk;

  hilo_muldiv_unit #(.WIDTH(32), .ITER(32)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Start    (Start),
    .Op       (Op),
    .A        (A),
    .B        (B),
    .Cancel   (Cancel),
    .HiLoRead (HiLoRead),
    .Busy     (Busy),
    .Done     (Done),
    .Stall    (Stall),
    .HiOUT    (HiOUT),
    .LoOUT    (LoOUT)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Arithmetic reference: {Hi,Lo} after the op, from plain integer math
  function automatic logic [63:0] refModel(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] hi,
                                           input logic [31:0] lo);
    longint      sa, sb, sq, sr;
    logic [63:0] ua, ub, sp, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    sp = sa * sb;
    case (op)
      c_MULT:  return sp;
      c_MULTU: return ua * ub;
      c_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
      c_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      c_MADD:  return {hi, lo} + sp;
      c_MSUB:  return {hi, lo} - sp;
      c_MTHI:  return {a, lo};
      default: return {hi, a};
    endcase
  endfunction

  function automatic logic [31:0] randOperand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard monitor: every Done must match the oldest expected result
  always @(negedge Clk) begin
    if (Rst && Done) begin
      if (expQ.size() == 0) begin
        check("doneWithoutOp", {63'd0, Done}, 64'd0);
      end else begin
        monExp = expQ.pop_front();
        check("hiloResult", {HiOUT, LoOUT}, monExp);
      end
    end
  end

  // Present one issue strobe; returns one time unit after the issue edge
  task automatic startOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1;
    Op    = op;
    A     = a;
    B     = b;
    @(posedge Clk);
    #1;
    Start = 1'b0;
  endtask

  // Ride out a long op, poking Start/HiLoRead, and check latency and pulse shape
  task automatic waitDone(input logic [63:0] prev);
    int n;
    n = 0;
    while (!Done && n <= 40) begin
      check("busyHigh", {63'd0, Busy}, 64'd1);
      check("hiloStable", {HiOUT, LoOUT}, prev);
      HiLoRead = 1'($urandom_range(0, 1));
      Start    = ($urandom_range(0, 3) == 0);
      Op       = 3'($urandom_range(0, 7));
      A        = $urandom;
      B        = $urandom;
      #1;
      check("stallWhileBusy", {63'd0, Stall}, {63'd0, HiLoRead | Start});
      @(posedge Clk);
      #1;
      n++;
    end
    Start    = 1'b0;
    HiLoRead = 1'b1;
    check("doneLatency", 64'(n), 64'd33);
    #1;
    check("doneCycleBusy", {63'd0, Busy}, 64'd0);
    check("doneCycleStall", {63'd0, Stall}, 64'd0);
    HiLoRead = 1'b0;
    @(posedge Clk);
    #1;
    check("doneOneCycle", {63'd0, Done}, 64'd0);
  endtask

  task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    logic [63:0] prev;
    prev = {mHi, mLo};
    e    = refModel(op, a, b, mHi, mLo);
    startOp(op, a, b);
    {mHi, mLo} = e;
    if (op == c_MTHI || op == c_MTLO) begin
      check("moveNoBusy", {63'd0, Busy}, 64'd0);
      check("moveHiLo", {HiOUT, LoOUT}, e);
    end else begin
      expQ.push_back(e);
      waitDone(prev);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int doneCount;
    // Reset state
    #12;
    check("rstBusy", {63'd0, Busy}, 64'd0);
    check("rstDone", {63'd0, Done}, 64'd0);
    check("rstHiLo", {HiOUT, LoOUT}, 64'd0);
    Rst = 1'b1;
    @(posedge Clk);
    #1;

    // Directed arithmetic cases
    runOp(c_MULT, 32'hFFFF_FFFD, 32'd5);
    check("mult-3x5", {HiOUT, LoOUT}, 64'hFFFF_FFFF_FFFF_FFF1);
    runOp(c_DIVU, 32'd100, 32'd7);
    check("divu100/7", {HiOUT, LoOUT}, {32'd2, 32'd14});
    runOp(c_DIV, 32'hFFFF_FFF9, 32'd2);
    check("div-7/2", {HiOUT, LoOUT}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    runOp(c_DIV, 32'd5, 32'd0);
    check("divByZero", {HiOUT, LoOUT}, {32'd5, 32'hFFFF_FFFF});
    runOp(c_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("divOverflow", {HiOUT, LoOUT}, {32'd0, 32'h8000_0000});
    runOp(c_MTHI, 32'd0, 32'd0);
    runOp(c_MTLO, 32'd10, 32'd0);
    runOp(c_MADD, 32'd4, 32'd5);
    check("madd", {HiOUT, LoOUT}, {32'd0, 32'd30});
    runOp(c_MSUB, 32'd1, 32'd31);
    check("msub", {HiOUT, LoOUT}, 64'hFFFF_FFFF_FFFF_FFFF);

    // Cancel in idle suppresses a same-cycle Start
    Start = 1'b1; Cancel = 1'b1; Op = c_MTHI; A = 32'h1234_5678;
    @(posedge Clk);
    #1;
    check("cancelIdleMove", {HiOUT, LoOUT}, {mHi, mLo});
    Op = c_MULT;
    @(posedge Clk);
    #1;
    Start = 1'b0; Cancel = 1'b0;
    check("cancelIdleLong", {63'd0, Busy}, 64'd0);

    // Cancel mid-run, with a second Start attempt while busy
    startOp(c_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (9) begin
      @(posedge Clk);
      #1;
    end
    Cancel = 1'b1; Start = 1'b1; Op = c_MULT; A = 32'd3; B = 32'd3;
    @(posedge Clk);
    #1;
    Cancel = 1'b0; Start = 1'b0;
    check("cancelBusyDrop", {63'd0, Busy}, 64'd0);
    check("cancelHiLo", {HiOUT, LoOUT}, {mHi, mLo});
    doneCount = 0;
    repeat (40) begin
      @(posedge Clk);
      #1;
      doneCount += int'(Done);
    end
    check("cancelNoDone", 64'(doneCount), 64'd0);
    check("cancelIgnoredStart", {63'd0, Busy}, 64'd0);

    // Cancel in the fix-up cycle blocks the write
    startOp(c_MULT, 32'd7, 32'd9);
    repeat (32) begin
      @(posedge Clk);
      #1;
    end
    check("fixBusy", {63'd0, Busy}, 64'd1);
    Cancel = 1'b1;
    @(posedge Clk);
    #1;
    Cancel = 1'b0;
    check("fixCancelBusy", {63'd0, Busy}, 64'd0);
    check("fixCancelDone", {63'd0, Done}, 64'd0);
    check("fixCancelHiLo", {HiOUT, LoOUT}, {mHi, mLo});

    // Randomized ops against the reference model
    repeat (30) begin
      runOp(3'($urandom_range(0, 7)), randOperand(), randOperand());
    end

    // Asynchronous reset in the middle of a divide
    startOp(c_DIV, $urandom, randOperand());
    repeat (19) begin
      @(posedge Clk);
      #1;
    end
    #2;
    Rst = 1'b0;
    HiLoRead = 1'b1;
    #1;
    check("asyncRstBusy", {63'd0, Busy}, 64'd0);
    check("asyncRstDone", {63'd0, Done}, 64'd0);
    check("asyncRstStall", {63'd0, Stall}, 64'd0);
    check("asyncRstHiLo", {HiOUT, LoOUT}, 64'd0);
    mHi = 32'd0;
    mLo = 32'd0;
    @(posedge Clk);
    #2;
    Rst = 1'b1;
    HiLoRead = 1'b0;
    @(posedge Clk);
    #1;
    runOp(c_MULT, 32'd2, 32'd3);
    check("postRstMult", {HiOUT, LoOUT}, {32'd0, 32'd6});

    repeat (5) begin
      @(posedge Clk);
      #1;
    end
    check("queueDrained", 64'(expQ.size()), 64'd0);
    check("finalHiLo", {HiOUT, LoOUT}, {mHi, mLo});

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
`default_nettype wire
